button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Parametrised multi-channel successor to the single-button debounce instances in the game top level. For each of N_CH raw push-button inputs it provides:
- a two-flop synchroniser and counter-based debounce;
- a debounced level;
- one-cycle press and release pulses;
- an optional per-channel auto-repeat strobe.

It sits between the board buttons and the game mechanism/VGA logic, replacing the separate reset/left/right debouncers. Held paddle buttons produce repeated move strobes.

Parameters:
- N_CH, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50_000_000, cycles from the press pulse to the first repeat pulse (500 ms); must be >= 1.
- REPEAT_RATE, 10_000_000, cycles between subsequent repeat pulses (100 ms); must be >= 1.
- CNT_W, 26, width of the per-channel counters; 2^CNT_W must exceed max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk_100MHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  N_CH  raw asynchronous button inputs, active high.
- repeat_en  input  N_CH  per-channel auto-repeat enable, synchronous to clk_100MHz.
- level  output  N_CH  debounced button state.
- press  output  N_CH  one-cycle pulse when level goes 0->1.
- released  output  N_CH  one-cycle pulse when level goes 1->0.
- rep  output  N_CH  one-cycle auto-repeat pulse.
- strobe  output  N_CH  press | rep, for move-per-event consumers.

Behaviour:
- Interface: one clock, clk_100MHz; reset is synchronous and active-high.
- Reset: synchroniser flops, counters, level, press, released, rep and strobe all 0 on the edge where reset=1. Reset mid-press drops level to 0 with no released pulse.
- All outputs are registered; channels are fully independent and may change in the same cycle.
- Synchroniser: two flops per channel. sync = btn_in delayed by 2 edges.
- Debounce, per channel:
  - If sync == level, the debounce counter clears to 0.
  - If sync != level, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, level toggles and the counter clears.
  - Net latency from a clean btn_in step to level change: DEBOUNCE_CYCLES+2 edges.
  - A glitch shorter than DEBOUNCE_CYCLES sync cycles leaves level unchanged; a bounce back to the level value restarts the count from 0.
- press / released: asserted for exactly the single cycle in which level has just changed (registered with level). They are never both high on one channel.
- Auto-repeat, per channel, as a 3-state FSM:
  - IDLE: level=0.
  - DELAY:
    - Entered on press with the hold counter at 0.
    - The counter increments each cycle.
    - When it reaches REPEAT_DELAY: rep pulses, counter clears, go to REPEAT.
  - REPEAT:
    - The counter increments each cycle.
    - When it reaches REPEAT_RATE: rep pulses and the counter clears.
  - Any state -> IDLE when level=0 (including on the released cycle); the counter clears.
  - repeat_en=0 while held: the FSM holds in DELAY with the counter at 0 and no rep is issued.
  - Re-asserting repeat_en restarts the full REPEAT_DELAY from that cycle.
  - Resulting rep timing: press in cycle t gives rep at t+REPEAT_DELAY, t+REPEAT_DELAY+REPEAT_RATE, and so on.
- strobe = press | rep, registered; rep and press never coincide.
- Counters saturate-free by construction given the CNT_W rule; no wrap-around is permitted.

Test Plan (N_CH=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, CNT_W=8):
- Reset: assert reset 2 cycles with btn_in=3'b111 -> all outputs 0. Deassert -> level[2:0]=3'b111 after 6 edges, and press=3'b111 for that one cycle.
- Debounce latency and glitch:
  - btn_in[0] 0->1 clean -> level[0]=1 and press[0]=1 exactly 6 edges later, press[0] low the next cycle.
  - A 3-cycle high pulse on btn_in[1] -> level[1], press[1] and released[1] stay 0.
- Bounce: btn_in[0] toggles 1,0,1 with 2-cycle spacing, then holds 1 -> level[0] rises 6 edges after the final rising edge, with a single press pulse.
- Auto-repeat: repeat_en[0]=1, btn_in[0] held 30 cycles -> press at cycle t, rep at t+10, t+13, t+16 ..., strobe matching press|rep. Release -> released pulse 6 edges after the falling edge and no further rep.
- repeat_en gating: hold btn_in[2] with repeat_en[2]=0 for 20 cycles -> no rep. Set repeat_en[2]=1 at cycle u -> first rep at u+10.
- Simultaneous and mid-reset: all channels press in the same cycle -> independent correct pulses. Assert reset during REPEAT -> level/rep 0 next edge, no released pulse, then normal re-acquisition after deassert.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchroniser, debouncer and auto-repeat strobe generator
module button_conditioner #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] rep,
  output logic [N_CH-1:0] strobe
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             sync_a, sync_b;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             level_q, level_nxt;
    logic             press_q, released_q, rep_q, strobe_q;
    logic             rep_nxt, press_nxt;
    rep_state_t       state, state_nxt;

    // Debounce: level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    always_comb begin
      level_nxt  = level_q;
      db_cnt_nxt = '0;
      if (sync_b != level_q) begin
        if (db_cnt == DB_LAST) level_nxt = ~level_q;
        else                   db_cnt_nxt = db_cnt + 1'b1;
      end
    end

    assign press_nxt = level_nxt & ~level_q;

    // Auto-repeat: decisions use the level being registered this edge so release wins at once.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = '0;
      rep_nxt      = 1'b0;
      if (!level_nxt) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:   state_nxt = DELAY;
          DELAY: begin
            if (repeat_en[ch]) begin
              if (hold_cnt == RD_LAST) begin
                rep_nxt   = 1'b1;
                state_nxt = REPEAT;
              end else begin
                hold_cnt_nxt = hold_cnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!repeat_en[ch])            state_nxt = DELAY;
            else if (hold_cnt == RR_LAST)  rep_nxt = 1'b1;
            else                           hold_cnt_nxt = hold_cnt + 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        sync_a     <= 1'b0;
        sync_b     <= 1'b0;
        db_cnt     <= '0;
        hold_cnt   <= '0;
        state      <= IDLE;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        released_q <= 1'b0;
        rep_q      <= 1'b0;
        strobe_q   <= 1'b0;
      end else begin
        sync_a     <= btn_in[ch];
        sync_b     <= sync_a;
        db_cnt     <= db_cnt_nxt;
        hold_cnt   <= hold_cnt_nxt;
        state      <= state_nxt;
        level_q    <= level_nxt;
        press_q    <= press_nxt;
        released_q <= ~level_nxt & level_q;
        rep_q      <= rep_nxt;
        strobe_q   <= press_nxt | rep_nxt;
      end
    end

    assign level[ch]    = level_q;
    assign press[ch]    = press_q;
    assign released[ch] = released_q;
    assign rep[ch]      = rep_q;
    assign strobe[ch]   = strobe_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
  localparam int N = 3, D = 4, RD = 10, RR = 3, W = 8;

  logic         clk_100MHz = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in, repeat_en;
  logic [N-1:0] level, press, released, rep, strobe;

  always #5 clk_100MHz = ~clk_100MHz;

  button_conditioner #(.N_CH(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
                       .REPEAT_RATE(RR), .CNT_W(W)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press(press), .released(released), .rep(rep), .strobe(strobe));

  int n_assert = 0, n_fail = 0, cyc = 0;

  // Reference: sync pipeline, mismatch-run start timestamps and repeat epochs.
  logic [N-1:0] m_s1, m_s2, m_lvl, e_press, e_rel, e_rep;
  int           mis_start[N], epoch[N];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic new_lvl;
    int   d;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; e_press = '0; e_rel = '0; e_rep = '0;
      for (int c = 0; c < N; c++) begin mis_start[c] = -1; epoch[c] = -1; end
      return;
    end
    for (int c = 0; c < N; c++) begin
      new_lvl = m_lvl[c];
      if (m_s2[c] != m_lvl[c]) begin
        if (mis_start[c] < 0) mis_start[c] = cyc;
        if (cyc - mis_start[c] + 1 == D) begin new_lvl = ~m_lvl[c]; mis_start[c] = -1; end
      end else begin
        mis_start[c] = -1;
      end
      e_press[c] = new_lvl & ~m_lvl[c];
      e_rel[c]   = ~new_lvl & m_lvl[c];
      e_rep[c]   = 1'b0;
      if (!new_lvl)                       epoch[c] = -1;
      else if (e_press[c] || !repeat_en[c]) epoch[c] = cyc;
      else begin
        d = cyc - epoch[c];
        e_rep[c] = (d == RD) || (d > RD && (d - RD) % RR == 0);
      end
      m_lvl[c] = new_lvl;
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    model_edge();
    #1;
    check("level", level, m_lvl);
    check("press", press, e_press);
    check("released", released, e_rel);
    check("rep", rep, e_rep);
    check("strobe", strobe, e_press | e_rep);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int lat, cnt, seen;

  initial begin
    reset = 1'b1; btn_in = 3'b111; repeat_en = '0;
    steps(2);
    check("rst_level", level, 3'b000);
    check("rst_strobe", strobe, 3'b000);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin step(); check("acq_early", level, 3'b000); end
    step();
    check("acq_level", level, 3'b111);
    check("acq_press", press, 3'b111);
    step();
    check("acq_press_off", press, 3'b000);
    btn_in = '0; steps(10);

    // clean step on channel 0
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin step(); check("db_early", level, 3'b000); end
    step();
    check("db_level", level, 3'b001);
    check("db_press", press, 3'b001);
    step();
    check("db_press_off", press, 3'b000);

    // 3-cycle glitch on channel 1
    btn_in[1] = 1'b1; steps(3); btn_in[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); cnt += int'(level[1] | press[1] | released[1]); end
    check_int("glitch_quiet", cnt, 0);

    // bounce 1,0,1 with 2-cycle spacing then hold
    btn_in[0] = 1'b0; steps(10);
    btn_in[0] = 1'b1; steps(2); btn_in[0] = 1'b0; steps(2); btn_in[0] = 1'b1;
    lat = -1; cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      cnt += int'(press[0]);
      if (lat < 0 && level[0]) lat = i;
    end
    check_int("bounce_latency", lat, 6);
    check_int("bounce_presses", cnt, 1);

    // auto-repeat on channel 0
    btn_in[0] = 1'b0; steps(10);
    repeat_en[0] = 1'b1; btn_in[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = int'(press[0]); end
    check_int("rep_press_seen", seen, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin step(); cnt += int'(rep[0]); end
    check_int("rep_count", cnt, 7);
    btn_in[0] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin step(); if (released[0]) lat = i; end
    check_int("rel_latency", lat, 6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(rep[0]); end
    check_int("rep_after_rel", cnt, 0);

    // repeat_en gating on channel 2
    repeat_en = '0; btn_in[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = int'(press[2]); end
    check_int("gate_press_seen", seen, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(rep[2]); end
    check_int("gate_no_rep", cnt, 0);
    repeat_en[2] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin step(); if (rep[2]) lat = i; end
    check_int("gate_first_rep", lat, RD);
    btn_in = '0; repeat_en = '0; steps(10);

    // simultaneous press, then reset while repeating
    repeat_en = 3'b111; btn_in = 3'b111;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = int'(press == 3'b111); end
    check_int("sim_press_seen", seen, 1);
    steps(14);
    reset = 1'b1; step();
    check("mid_rst_level", level, 3'b000);
    check("mid_rst_rep", rep, 3'b000);
    check("mid_rst_released", released, 3'b000);
    reset = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin step(); if (level == 3'b111) lat = i; end
    check_int("reacq_latency", lat, 6);

    // randomized activity against the reference
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(7) == 0)  btn_in[c] = ~btn_in[c];
        if ($urandom_range(40) == 0) repeat_en[c] = ~repeat_en[c];
      end
      reset = ($urandom_range(300) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
